// File: rtl/io_write_arbiter_if.sv
// Requester-side bus for io_write_arbiter: CPU (0) and aux (1) write requests plus their acks.
interface io_write_arbiter_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          req0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] data0;
  logic          req1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] data1;
  logic          ack0;
  logic          ack1;

  modport master (
    output req0, addr0, data0, req1, addr1, data1,
    input  ack0, ack1
  );

  modport slave (
    input  req0, addr0, data0, req1, addr1, data1,
    output ack0, ack1
  );
endinterface

// File: rtl/io_write_arbiter.sv
// Round-robin arbiter sharing the output-port write path between the CPU store path and an aux master.
// Define IO_WR_ADDR_CHECK_EN to suppress writes to out-of-range ports and flag them on err.
module io_write_arbiter #(
  parameter logic [5:0]  BASE_SEL  = 6'b100000,
  parameter int unsigned NPORTS    = 3,
  parameter bit          PRIO_INIT = 1'b0
) (
  input  logic               io_clk,
  input  logic               reset,
  io_write_arbiter_if.slave  bus,
  output logic [31:0]        io_addr,
  output logic [31:0]        io_datain,
  output logic               io_write_enable,
  output logic               busy,
  output logic               err
);

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned SEL_W = 6;

`ifdef IO_WR_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  typedef enum logic {IDLE, WR} state_t;

  state_t        state, state_nxt;
  logic          prio, prio_nxt;
  logic          ack0_reg, ack1_reg;
  logic          ack0_nxt, ack1_nxt;
  logic [AW-1:0] addr_nxt;
  logic [DW-1:0] data_nxt;
  logic          we_nxt, busy_nxt, err_nxt;

  logic             gnt1;
  logic [AW-1:0]    win_addr;
  logic [DW-1:0]    win_data;
  logic [SEL_W-1:0] win_off;
  logic             in_range;

  assign bus.ack0 = ack0_reg;
  assign bus.ack1 = ack1_reg;

  // Winner selection and port-range decode of the winning address (word offset from BASE_SEL, mod 64).
  always_comb begin
    gnt1     = bus.req1 && (!bus.req0 || prio);
    win_addr = gnt1 ? bus.addr1 : bus.addr0;
    win_data = gnt1 ? bus.data1 : bus.data0;
    win_off  = win_addr[7:2] - BASE_SEL;
    in_range = (win_off < SEL_W'(NPORTS));
  end

  // Next-state and next-output logic; strobes default low so they last only the WR cycle.
  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    addr_nxt  = io_addr;
    data_nxt  = io_datain;
    we_nxt    = 1'b0;
    busy_nxt  = 1'b0;
    err_nxt   = 1'b0;
    ack0_nxt  = 1'b0;
    ack1_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_nxt = WR;
          prio_nxt  = ~gnt1;
          addr_nxt  = win_addr;
          data_nxt  = win_data;
          busy_nxt  = 1'b1;
          ack0_nxt  = ~gnt1;
          ack1_nxt  = gnt1;
          we_nxt    = !ADDR_CHECK || in_range;
          err_nxt   = ADDR_CHECK && !in_range;
        end
      end
      WR: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge io_clk) begin
    if (reset) begin
      state           <= IDLE;
      prio            <= PRIO_INIT;
      io_addr         <= '0;
      io_datain       <= '0;
      io_write_enable <= 1'b0;
      busy            <= 1'b0;
      err             <= 1'b0;
      ack0_reg        <= 1'b0;
      ack1_reg        <= 1'b0;
    end else begin
      state           <= state_nxt;
      prio            <= prio_nxt;
      io_addr         <= addr_nxt;
      io_datain       <= data_nxt;
      io_write_enable <= we_nxt;
      busy            <= busy_nxt;
      err             <= err_nxt;
      ack0_reg        <= ack0_nxt;
      ack1_reg        <= ack1_nxt;
    end
  end

endmodule
